// File: rtl/prf_free_list_pkg.sv
// Shared widths, tag/pointer types and the popcount/compaction helpers
// used by the physical register free list and its release compactor.
package prf_free_list_pkg;

    localparam int PREG_DEPTH  = 64;
    localparam int AREG_COUNT  = 32;
    localparam int ALLOC_PORTS = 2;
    localparam int FREE_PORTS  = 4;

    localparam int TAG_W  = $clog2(PREG_DEPTH);
    localparam int PTR_W  = TAG_W + 1;
    localparam int CNT_W  = $clog2(PREG_DEPTH + 1);
    localparam int RCNT_W = $clog2(ALLOC_PORTS + 1);
    localparam int OFF_W  = $clog2(FREE_PORTS + 1);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [OFF_W-1:0] off_t;
    typedef off_t [FREE_PORTS-1:0] off_vec_t;

    function automatic off_t popcount_free(input logic [FREE_PORTS-1:0] v);
        off_t c;
        c = '0;
        for (int i = 0; i < FREE_PORTS; i++) begin
            c = c + off_t'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [RCNT_W-1:0] popcount_alloc(input logic [ALLOC_PORTS-1:0] v);
        logic [RCNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            c = c + (RCNT_W)'(v[i]);
        end
        return c;
    endfunction

    // Exclusive prefix sum: each port's write slot relative to the tail.
    function automatic off_vec_t compact_offsets(input logic [FREE_PORTS-1:0] v);
        off_vec_t offs;
        off_t     run;
        run = '0;
        for (int i = 0; i < FREE_PORTS; i++) begin
            offs[i] = run;
            run     = run + off_t'(v[i]);
        end
        return offs;
    endfunction

endpackage

// File: rtl/prf_free_compactor.sv
// Prefix-sum offset generator packing enabled release ports into
// consecutive slots; also usable by the ROB commit path.
module prf_free_compactor
    import prf_free_list_pkg::*;
(
    input  logic [FREE_PORTS-1:0] valid,
    output off_vec_t              offset,
    output off_t                  total
);

    assign offset = compact_offsets(valid);
    assign total  = popcount_free(valid);

endmodule

// File: rtl/prf_free_list.sv
// Circular free-tag FIFO with speculative and retire heads; flush
// rewinds the speculative head to the retire head in one cycle.
module prf_free_list
    import prf_free_list_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Stall,
    input  logic                          Flush,
    input  logic [ALLOC_PORTS-1:0]        AllocReq,
    output logic                          AllocRdy,
    output logic [ALLOC_PORTS*TAG_W-1:0]  AllocTag,
    input  logic [RCNT_W-1:0]             RetireCnt,
    input  logic [FREE_PORTS-1:0]         FreeEn,
    input  logic [FREE_PORTS*TAG_W-1:0]   FreeTag,
    output logic [CNT_W-1:0]              FreeCount
);

    tag_t     mem [PREG_DEPTH];
    ptr_t     spec_head, ret_head, tail;
    ptr_t     spec_head_nx, ret_head_nx, tail_nx;
    ptr_t     spec_free;
    logic     fire;
    off_vec_t free_off;
    off_t     free_total;

    prf_free_compactor u_compactor (
        .valid  (FreeEn),
        .offset (free_off),
        .total  (free_total)
    );

    assign spec_free = tail - spec_head;
    assign AllocRdy  = (spec_free >= ptr_t'(ALLOC_PORTS));
    assign fire      = AllocReq[0] & AllocRdy & ~Stall & ~Flush;

    for (genvar k = 0; k < ALLOC_PORTS; k++) begin : g_alloc_tag
        assign AllocTag[k*TAG_W +: TAG_W] = mem[spec_head[TAG_W-1:0] + tag_t'(k)];
    end

    always_comb begin
        spec_head_nx = spec_head;
        ret_head_nx  = ret_head;
        tail_nx      = tail;
        if (!Stall) begin
            ret_head_nx = ret_head + ptr_t'(RetireCnt);
            tail_nx     = tail + ptr_t'(free_total);
            // Flush folds in this cycle's retirements so nothing committed is lost.
            if (Flush) begin
                spec_head_nx = ret_head + ptr_t'(RetireCnt);
            end else if (fire) begin
                spec_head_nx = spec_head + ptr_t'(popcount_alloc(AllocReq));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_head <= '0;
            ret_head  <= '0;
            tail      <= ptr_t'(PREG_DEPTH - AREG_COUNT);
            FreeCount <= CNT_W'(PREG_DEPTH - AREG_COUNT);
            for (int i = 0; i < PREG_DEPTH; i++) begin
                mem[i] <= tag_t'(i + AREG_COUNT);
            end
        end else begin
            spec_head <= spec_head_nx;
            ret_head  <= ret_head_nx;
            tail      <= tail_nx;
            FreeCount <= CNT_W'(tail_nx - spec_head_nx);
            if (!Stall) begin
                for (int p = 0; p < FREE_PORTS; p++) begin
                    if (FreeEn[p]) begin
                        mem[tail[TAG_W-1:0] + tag_t'(free_off[p])] <= FreeTag[p*TAG_W +: TAG_W];
                    end
                end
            end
        end
    end

    a_retire_bound: assert property (@(posedge clk) disable iff (rst)
        !Stall |-> (ptr_t'(RetireCnt) <= ptr_t'(spec_head - ret_head)));

    // Exceeding the depth can only come from a double free upstream.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        ptr_t'(tail - ret_head) <= ptr_t'(PREG_DEPTH));

endmodule

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list: reset state, allocation to empty,
// alloc/free overlap, retire+flush recovery, stall hold and gapped release.
module tb_prf_free_list;
    import prf_free_list_pkg::*;

    logic                          clk;
    logic                          rst;
    logic                          Stall;
    logic                          Flush;
    logic [ALLOC_PORTS-1:0]        AllocReq;
    logic                          AllocRdy;
    logic [ALLOC_PORTS*TAG_W-1:0]  AllocTag;
    logic [RCNT_W-1:0]             RetireCnt;
    logic [FREE_PORTS-1:0]         FreeEn;
    logic [FREE_PORTS*TAG_W-1:0]   FreeTag;
    logic [CNT_W-1:0]              FreeCount;

    int tests_run;
    int tests_failed;

    prf_free_list dut (
        .clk       (clk),
        .rst       (rst),
        .Stall     (Stall),
        .Flush     (Flush),
        .AllocReq  (AllocReq),
        .AllocRdy  (AllocRdy),
        .AllocTag  (AllocTag),
        .RetireCnt (RetireCnt),
        .FreeEn    (FreeEn),
        .FreeTag   (FreeTag),
        .FreeCount (FreeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int slot(input int k);
        return int'(AllocTag[k*TAG_W +: TAG_W]);
    endfunction

    task automatic set_free_tag(input int port, input int tag);
        FreeTag[port*TAG_W +: TAG_W] = tag_t'(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        Stall     = 1'b0;
        Flush     = 1'b0;
        AllocReq  = '0;
        RetireCnt = '0;
        FreeEn    = '0;
        FreeTag   = '0;
        step();
        step();
        rst = 1'b0;

        check("reset_free_count", int'(FreeCount), 32);
        check("reset_alloc_rdy", int'(AllocRdy), 1);
        check("reset_tag0", slot(0), 32);
        check("reset_tag1", slot(1), 33);

        // Drain all 32 free tags two per cycle.
        AllocReq = 2'b11;
        for (int i = 0; i < 16; i++) begin
            check("drain_rdy", int'(AllocRdy), 1);
            check("drain_tag0", slot(0), 32 + 2*i);
            check("drain_tag1", slot(1), 33 + 2*i);
            step();
        end
        check("empty_free_count", int'(FreeCount), 0);
        check("empty_alloc_rdy", int'(AllocRdy), 0);
        step();
        check("req_when_empty_count", int'(FreeCount), 0);

        AllocReq = 2'b00;
        FreeEn   = 4'b0001;
        set_free_tag(0, 6);
        step();
        check("one_free_count", int'(FreeCount), 1);
        check("one_free_rdy", int'(AllocRdy), 0);

        // Single-slot request with only one tag free must not fire.
        AllocReq = 2'b01;
        set_free_tag(0, 5);
        check("one_free_req_rdy", int'(AllocRdy), 0);
        step();
        AllocReq = 2'b00;
        FreeEn   = 4'b0000;
        check("two_free_count", int'(FreeCount), 2);
        check("two_free_rdy", int'(AllocRdy), 1);
        check("two_free_tag0", slot(0), 6);
        check("two_free_tag1", slot(1), 5);

        // Reset mid-operation with Stall/Flush/AllocReq all active.
        rst      = 1'b1;
        Stall    = 1'b1;
        Flush    = 1'b1;
        AllocReq = 2'b11;
        step();
        rst      = 1'b0;
        Stall    = 1'b0;
        Flush    = 1'b0;
        AllocReq = 2'b00;
        check("rst_override_count", int'(FreeCount), 32);
        check("rst_override_tag0", slot(0), 32);
        check("rst_override_tag1", slot(1), 33);

        AllocReq = 2'b11;
        step();
        step();
        AllocReq = 2'b00;
        check("alloc4_count", int'(FreeCount), 28);
        check("alloc4_tag0", slot(0), 36);

        RetireCnt = 2'd2;
        step();
        RetireCnt = 2'd0;
        check("retire_count", int'(FreeCount), 28);

        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush_count", int'(FreeCount), 30);
        check("flush_tag0", slot(0), 34);
        check("flush_tag1", slot(1), 35);

        // Gapped release held off by Stall.
        Stall    = 1'b1;
        AllocReq = 2'b11;
        FreeEn   = 4'b1011;
        set_free_tag(0, 3);
        set_free_tag(1, 7);
        set_free_tag(2, 42);
        set_free_tag(3, 9);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_count", int'(FreeCount), 30);
            check("stall_tag0", slot(0), 34);
        end
        Stall    = 1'b0;
        AllocReq = 2'b00;
        step();
        FreeEn = 4'b0000;
        check("release3_count", int'(FreeCount), 33);

        AllocReq = 2'b11;
        for (int i = 0; i < 15; i++) begin
            check("walk_tag0", slot(0), 34 + 2*i);
            check("walk_tag1", slot(1), 35 + 2*i);
            step();
        end
        check("appended_count", int'(FreeCount), 3);
        check("appended_tag0", slot(0), 3);
        check("appended_tag1", slot(1), 7);
        step();
        AllocReq = 2'b00;
        check("last_count", int'(FreeCount), 1);
        check("last_rdy", int'(AllocRdy), 0);
        check("last_tag0", slot(0), 9);

        FreeEn = 4'b0011;
        set_free_tag(0, 11);
        set_free_tag(1, 12);
        step();
        FreeEn = 4'b0000;
        check("refill_count", int'(FreeCount), 3);
        check("refill_rdy", int'(AllocRdy), 1);
        check("refill_tag1", slot(1), 11);

        // Flush with same-cycle retire, release and a ready alloc request.
        AllocReq  = 2'b11;
        Flush     = 1'b1;
        RetireCnt = 2'd1;
        FreeEn    = 4'b0001;
        set_free_tag(0, 13);
        step();
        AllocReq  = 2'b00;
        RetireCnt = 2'd0;
        FreeEn    = 4'b0000;
        check("flush_retire_count", int'(FreeCount), 35);
        check("flush_retire_tag0", slot(0), 35);
        check("flush_retire_tag1", slot(1), 36);
        step();
        Flush = 1'b0;
        check("reflush_count", int'(FreeCount), 35);
        check("reflush_tag0", slot(0), 35);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
